// File: rtl/id_pkg.sv
// id_pkg: shared constants for the ID stage.
//   - OPC_*  : major opcode values of inst[6:2]
//   - TYPE_* : one-hot inst_type codes ([4] arith, [3] logic, [2] ld/st, [1] jump/branch, [0] sys)
//   - alu_op_e : internal execute opcode; W forms sit at base + 8'h10
//   - alu_op() : funct3/alt/W -> ALU opcode for OP, OP-IMM and their W forms
package id_pkg;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  localparam logic [4:0] TYPE_ARITH = 5'b10000;
  localparam logic [4:0] TYPE_LOGIC = 5'b01000;
  localparam logic [4:0] TYPE_LDST  = 5'b00100;
  localparam logic [4:0] TYPE_JB    = 5'b00010;
  localparam logic [4:0] TYPE_SYS   = 5'b00001;

  typedef enum logic [7:0] {
    ALU_NOP  = 8'h00,
    ALU_ADD  = 8'h11, ALU_SUB  = 8'h12, ALU_SLL  = 8'h13, ALU_SLT  = 8'h14,
    ALU_SLTU = 8'h15, ALU_XOR  = 8'h16, ALU_SRL  = 8'h17, ALU_SRA  = 8'h18,
    ALU_OR   = 8'h19, ALU_AND  = 8'h1A,
    ALU_ADDW = 8'h21, ALU_SUBW = 8'h22, ALU_SLLW = 8'h23, ALU_SRLW = 8'h27,
    ALU_SRAW = 8'h28,
    ALU_JAL  = 8'h30, ALU_JALR = 8'h31,
    // branch / load / store codes are 8'h40/50/60 | funct3
    ALU_BEQ  = 8'h40, ALU_BNE  = 8'h41, ALU_BLT  = 8'h44, ALU_BGE  = 8'h45,
    ALU_BLTU = 8'h46, ALU_BGEU = 8'h47,
    ALU_LB   = 8'h50, ALU_LH   = 8'h51, ALU_LW   = 8'h52, ALU_LD   = 8'h53,
    ALU_LBU  = 8'h54, ALU_LHU  = 8'h55, ALU_LWU  = 8'h56,
    ALU_SB   = 8'h60, ALU_SH   = 8'h61, ALU_SW   = 8'h62, ALU_SD   = 8'h63,
    ALU_ECALL = 8'h70, ALU_EBREAK = 8'h71
  } alu_op_e;

  function automatic logic [7:0] alu_op(input logic [2:0] f3, input logic alt, input logic w);
    logic [7:0] r;
    case (f3)
      3'd0:    r = alt ? ALU_SUB : ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = alt ? ALU_SRA : ALU_SRL;
      3'd6:    r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return w ? r + 8'h10 : r;
  endfunction

endpackage

// File: rtl/id_stage_pipe_decode.sv
// id_decode_comb: purely combinational RV32I/RV64I decode.
//   in : inst, pc, in_valid, rs1_data, rs2_data
//   out: regfile read requests (rsN_r_ena/addr) and the decoded bundle
//        (inst_type, inst_opcode, op1, op2, imm, rs2_val, rd_w_ena, rd_w_addr, illegal)
module id_decode_comb
  import id_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] pc,
  input  logic            in_valid,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            rs1_r_ena,
  output logic [4:0]      rs1_r_addr,
  output logic            rs2_r_ena,
  output logic [4:0]      rs2_r_addr,
  output logic [4:0]      inst_type,
  output logic [7:0]      inst_opcode,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] rs2_val,
  output logic            rd_w_ena,
  output logic [4:0]      rd_w_addr,
  output logic            illegal
);
  localparam logic RV64 = (XLEN == 64);

  logic [4:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [XLEN-1:0] i_x, s_x, b_x, u_x, j_x, pc_x;
  logic use_rs1, use_rs2, use_rd, ill, w, alt;
  logic [5:0] shamt;

  assign opc  = inst[6:2];
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];
  assign pc_x = XLEN'(pc);
  assign i_x  = XLEN'($signed(inst[31:20]));
  assign s_x  = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign b_x  = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign u_x  = XLEN'($signed({inst[31:12], 12'b0}));
  assign j_x  = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    inst_type = '0; inst_opcode = ALU_NOP; op1 = '0; op2 = '0; imm = '0; rs2_val = '0;
    use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0; ill = 1'b0; w = 1'b0; alt = 1'b0;
    shamt = '0;
    if (inst[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        OPC_OP, OPC_OP_32: begin
          w = opc[1];
          alt = (f7 == 7'b0100000);
          use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
          op1 = rs1_data; op2 = rs2_data;
          inst_opcode = alu_op(f3, alt, w);
          inst_type = (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd3) ? TYPE_ARITH : TYPE_LOGIC;
          ill = !(f7 == 7'd0 || (alt && (f3 == 3'd0 || f3 == 3'd5))) ||
                (w && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) || (w && !RV64);
        end
        OPC_OP_IMM, OPC_OP_IMM_32: begin
          w = opc[1];
          use_rs1 = 1'b1; use_rd = 1'b1;
          op1 = rs1_data;
          inst_type = (f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd3) ? TYPE_ARITH : TYPE_LOGIC;
          if (f3 == 3'd1 || f3 == 3'd5) begin
            alt = inst[30];
            // 6-bit shamt only for non-W shifts on RV64; otherwise imm[5] belongs to funct7
            shamt = {inst[25] & RV64 & ~w, inst[24:20]};
            if (RV64 && !w) ill = (inst[31:26] != {1'b0, alt, 4'b0000});
            else            ill = (inst[31:25] != {1'b0, alt, 5'b00000});
            if (f3 == 3'd1 && alt) ill = 1'b1;
            op2 = XLEN'(shamt);
            imm = XLEN'(shamt);
          end else begin
            op2 = i_x; imm = i_x;
            ill = w && (f3 != 3'd0);
          end
          inst_opcode = alu_op(f3, alt, w);
          if (w && !RV64) ill = 1'b1;
        end
        OPC_LUI, OPC_AUIPC: begin
          use_rd = 1'b1;
          op1 = (opc == OPC_AUIPC) ? pc_x : '0;
          op2 = u_x; imm = u_x;
          inst_opcode = ALU_ADD; inst_type = TYPE_ARITH;
        end
        OPC_JAL, OPC_JALR: begin
          use_rd = 1'b1;
          op1 = pc_x; op2 = XLEN'(4);
          inst_type = TYPE_JB;
          if (opc == OPC_JAL) begin
            imm = j_x; inst_opcode = ALU_JAL;
          end else begin
            // op1 carries the link PC, so the JALR base rides on the rs2 lane
            use_rs1 = 1'b1; imm = i_x; rs2_val = rs1_data;
            inst_opcode = ALU_JALR; ill = (f3 != 3'd0);
          end
        end
        OPC_BRANCH: begin
          use_rs1 = 1'b1; use_rs2 = 1'b1;
          op1 = rs1_data; op2 = rs2_data; imm = b_x; rs2_val = rs2_data;
          inst_opcode = {5'b01000, f3}; inst_type = TYPE_JB;
          ill = (f3 == 3'd2 || f3 == 3'd3);
        end
        OPC_LOAD: begin
          use_rs1 = 1'b1; use_rd = 1'b1;
          op1 = rs1_data; op2 = i_x; imm = i_x;
          inst_opcode = {5'b01010, f3}; inst_type = TYPE_LDST;
          ill = (f3 == 3'd7) || (!RV64 && (f3 == 3'd3 || f3 == 3'd6));
        end
        OPC_STORE: begin
          use_rs1 = 1'b1; use_rs2 = 1'b1;
          op1 = rs1_data; op2 = s_x; imm = s_x; rs2_val = rs2_data;
          inst_opcode = {5'b01100, f3}; inst_type = TYPE_LDST;
          ill = f3[2] || (!RV64 && f3 == 3'd3);
        end
        OPC_SYSTEM: begin
          inst_type = TYPE_SYS;
          if (inst == 32'h0000_0073)      inst_opcode = ALU_ECALL;
          else if (inst == 32'h0010_0073) inst_opcode = ALU_EBREAK;
          else                            ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      inst_type = TYPE_SYS; inst_opcode = ALU_NOP;
      op1 = '0; op2 = '0; imm = '0; rs2_val = '0;
      use_rs1 = 1'b0; use_rs2 = 1'b0; use_rd = 1'b0;
    end
  end

  assign illegal    = ill;
  assign rs1_r_ena  = in_valid && use_rs1;
  assign rs1_r_addr = rs1_r_ena ? inst[19:15] : 5'd0;
  assign rs2_r_ena  = in_valid && use_rs2;
  assign rs2_r_addr = rs2_r_ena ? inst[24:20] : 5'd0;
  assign rd_w_ena   = use_rd && (inst[11:7] != 5'd0);
  assign rd_w_addr  = use_rd ? inst[11:7] : 5'd0;

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: registered ID stage; decode + valid/ready ID/EX register.
//   in : clk, rst_n (async low), flush, in_valid/in_inst/in_pc, rs1_data/rs2_data, out_ready
//   out: in_ready, rs1/rs2 read requests, out_valid and the out_* decoded entry
// Optional macro ID_SKID_EN: one-entry skid buffer, in_ready driven from a flop.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            rs1_r_ena,
  output logic [4:0]      rs1_r_addr,
  output logic            rs2_r_ena,
  output logic [4:0]      rs2_r_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_inst_type,
  output logic [7:0]      out_inst_opcode,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_rs2_data,
  output logic            out_rd_w_ena,
  output logic [4:0]      out_rd_w_addr,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);
  typedef struct packed {
    logic [4:0]      itype;
    logic [7:0]      opc;
    logic [XLEN-1:0] op1, op2, imm, rs2d;
    logic            rd_we;
    logic [4:0]      rd;
    logic [PC_W-1:0] pc;
    logic            ill;
  } ent_t;

  logic [4:0] d_itype, d_rd;
  logic [7:0] d_opc;
  logic [XLEN-1:0] d_op1, d_op2, d_imm, d_rs2d;
  logic d_rd_we, d_ill, capture;
  ent_t dec_e, ent_d, ent_q;
  logic out_valid_d, out_valid_q;

  id_decode_comb #(.XLEN(XLEN), .PC_W(PC_W)) u_dec (
    .inst(in_inst), .pc(in_pc), .in_valid(in_valid),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .inst_type(d_itype), .inst_opcode(d_opc), .op1(d_op1), .op2(d_op2),
    .imm(d_imm), .rs2_val(d_rs2d), .rd_w_ena(d_rd_we), .rd_w_addr(d_rd),
    .illegal(d_ill)
  );

  always_comb begin
    dec_e = '0;
    dec_e.itype = d_itype; dec_e.opc = d_opc; dec_e.op1 = d_op1; dec_e.op2 = d_op2;
    dec_e.imm = d_imm; dec_e.rs2d = d_rs2d; dec_e.rd_we = d_rd_we; dec_e.rd = d_rd;
    dec_e.pc = in_pc; dec_e.ill = d_ill;
  end

`ifdef ID_SKID_EN
  ent_t skid_d, skid_q;
  logic skid_valid_d, skid_valid_q, in_ready_d, in_ready_q;

  assign in_ready = in_ready_q;

  always_comb begin
    ent_d = ent_q; skid_d = skid_q;
    out_valid_d = out_valid_q; skid_valid_d = skid_valid_q;
    capture = in_valid && in_ready_q && !flush;
    if (flush) begin
      out_valid_d = 1'b0; skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // main slot frees up: skid entry (older) goes first
      if (skid_valid_q) begin
        ent_d = skid_q; out_valid_d = 1'b1; skid_valid_d = 1'b0;
      end else if (capture) begin
        ent_d = dec_e; out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (capture) begin
      skid_d = dec_e; skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    ent_d = ent_q;
    out_valid_d = out_valid_q;
    capture = in_valid && in_ready && !flush;
    if (flush)          out_valid_d = 1'b0;
    else if (capture) begin
      ent_d = dec_e; out_valid_d = 1'b1;
    end else if (out_ready) out_valid_d = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q       <= '0;
      out_valid_q <= 1'b0;
`ifdef ID_SKID_EN
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
`endif
    end else begin
      ent_q       <= ent_d;
      out_valid_q <= out_valid_d;
`ifdef ID_SKID_EN
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
`endif
    end
  end

  assign out_valid       = out_valid_q;
  assign out_inst_type   = ent_q.itype;
  assign out_inst_opcode = ent_q.opc;
  assign out_op1         = ent_q.op1;
  assign out_op2         = ent_q.op2;
  assign out_imm         = ent_q.imm;
  assign out_rs2_data    = ent_q.rs2d;
  assign out_rd_w_ena    = ent_q.rd_we;
  assign out_rd_w_addr   = ent_q.rd;
  assign out_pc          = ent_q.pc;
  assign out_illegal     = ent_q.ill;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed bench; an RV64 and an RV32 instance run in lockstep
// on the same stimulus, expected values are hand-computed constants.
module tb_id_stage_pipe;
  logic clk = 1'b0;
  logic rst_n, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, rs1_data, rs2_data;

  // RV64 instance
  logic a_in_ready, a_rs1_en, a_rs2_en, a_ov, a_rd_we, a_ill;
  logic [4:0] a_rs1_a, a_rs2_a, a_type, a_rd;
  logic [7:0] a_opc;
  logic [63:0] a_op1, a_op2, a_imm, a_rs2d, a_pc;
  // RV32 instance
  logic b_in_ready, b_rs1_en, b_rs2_en, b_ov, b_rd_we, b_ill;
  logic [4:0] b_rs1_a, b_rs2_a, b_type, b_rd;
  logic [7:0] b_opc;
  logic [31:0] b_op1, b_op2, b_imm, b_rs2d, b_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(64), .PC_W(64)) u64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .rs1_r_ena(a_rs1_en), .rs1_r_addr(a_rs1_a), .rs2_r_ena(a_rs2_en), .rs2_r_addr(a_rs2_a),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(a_ov), .out_ready(out_ready), .out_inst_type(a_type), .out_inst_opcode(a_opc),
    .out_op1(a_op1), .out_op2(a_op2), .out_imm(a_imm), .out_rs2_data(a_rs2d),
    .out_rd_w_ena(a_rd_we), .out_rd_w_addr(a_rd), .out_pc(a_pc), .out_illegal(a_ill)
  );

  id_stage_pipe #(.XLEN(32), .PC_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]),
    .rs1_r_ena(b_rs1_en), .rs1_r_addr(b_rs1_a), .rs2_r_ena(b_rs2_en), .rs2_r_addr(b_rs2_a),
    .rs1_data(rs1_data[31:0]), .rs2_data(rs2_data[31:0]),
    .out_valid(b_ov), .out_ready(out_ready), .out_inst_type(b_type), .out_inst_opcode(b_opc),
    .out_op1(b_op1), .out_op2(b_op2), .out_imm(b_imm), .out_rs2_data(b_rs2d),
    .out_rd_w_ena(b_rd_we), .out_rd_w_addr(b_rd), .out_pc(b_pc), .out_illegal(b_ill)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive at negedge, sample combinational outputs 1 time unit later
  task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc; rs1_data = r1; rs2_data = r2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 64'h0; rs1_data = 64'h0; rs2_data = 64'h0;
    #2;
    check("rst_valid64", a_ov, 0);
    check("rst_op1_64", a_op1, 0);
    check("rst_type64", a_type, 0);
    check("rst_valid32", b_ov, 0);
    check("rst_pc32", b_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi x1,x2,5
    drive(1, 32'h0051_0093, 64'h1000, 64'd7, 64'd0);
    check("addi_rs1_en", a_rs1_en, 1);
    check("addi_rs1_addr", a_rs1_a, 2);
    check("addi_rs2_en", a_rs2_en, 0);
    tick();
    check("addi_valid", a_ov, 1);
    check("addi_opc", a_opc, 8'h11);
    check("addi_type", a_type, 5'b10000);
    check("addi_op1", a_op1, 7);
    check("addi_op2", a_op2, 5);
    check("addi_rd", a_rd, 1);
    check("addi_rd_we", a_rd_we, 1);
    check("addi_pc", a_pc, 64'h1000);
    check("addi_op2_32", b_op2, 5);

    // addi x3,x0,-1
    drive(1, 32'hFFF0_0193, 64'h1004, 64'd0, 64'd0);
    tick();
    check("neg_op2_64", a_op2, 64'hFFFF_FFFF_FFFF_FFFF);
    check("neg_op2_32", b_op2, 64'hFFFF_FFFF);
    check("neg_imm_64", a_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("neg_rd", a_rd, 3);

    // back-pressure: add x2,x1,x2 waits behind the held addi
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h0020_8133, 64'h1008, 64'd10, 64'd20);
      check("bp_in_ready", a_in_ready, 0);
      tick();
      check("bp_valid", a_ov, 1);
      check("bp_op2_hold", a_op2, 64'hFFFF_FFFF_FFFF_FFFF);
      check("bp_rd_hold", a_rd, 3);
      check("bp_pc_hold", a_pc, 64'h1004);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", a_in_ready, 1);
    tick();
    check("bp_add_op1", a_op1, 10);
    check("bp_add_op2", a_op2, 20);
    check("bp_add_rd", a_rd, 2);
    check("bp_add_pc", a_pc, 64'h1008);

    // sub x5,x6,x7
    drive(1, 32'h4073_02B3, 64'h100C, 64'd100, 64'd30);
    check("sub_rs2_addr", a_rs2_a, 7);
    tick();
    check("sub_opc", a_opc, 8'h12);
    check("sub_op2", a_op2, 30);
    check("sub_type", a_type, 5'b10000);

    // srai x1,x2,33: legal at 64, imm[5]=1 illegal at 32
    drive(1, 32'h4211_5093, 64'h1010, 64'hF0, 64'd0);
    tick();
    check("srai_opc64", a_opc, 8'h18);
    check("srai_op2_64", a_op2, 33);
    check("srai_type64", a_type, 5'b01000);
    check("srai_op1_64", a_op1, 64'hF0);
    check("srai_ill64", a_ill, 0);
    check("srai_ill32", b_ill, 1);
    check("srai_type32", b_type, 5'b00001);
    check("srai_op1_32", b_op1, 0);

    // sw x2,8(x1)
    drive(1, 32'h0020_A423, 64'h1014, 64'h200, 64'hABCD);
    check("sw_rs2_en", a_rs2_en, 1);
    tick();
    check("sw_opc", a_opc, 8'h62);
    check("sw_op2", a_op2, 8);
    check("sw_rs2d", a_rs2d, 64'hABCD);
    check("sw_rd_we", a_rd_we, 0);
    check("sw_type", a_type, 5'b00100);

    // jal x1,+16
    drive(1, 32'h0100_00EF, 64'h2000, 64'd0, 64'd0);
    check("jal_rs1_en", a_rs1_en, 0);
    tick();
    check("jal_op1", a_op1, 64'h2000);
    check("jal_op2", a_op2, 4);
    check("jal_imm", a_imm, 16);
    check("jal_opc", a_opc, 8'h30);
    check("jal_type", a_type, 5'b00010);

    // lui x5,0x80000
    drive(1, 32'h8000_02B7, 64'h2004, 64'd0, 64'd0);
    tick();
    check("lui_op2_64", a_op2, 64'hFFFF_FFFF_8000_0000);
    check("lui_op2_32", b_op2, 64'h8000_0000);
    check("lui_op1", a_op1, 0);

    // all-zero word
    drive(1, 32'h0000_0000, 64'h2008, 64'd5, 64'd6);
    check("ill_rs1_en", a_rs1_en, 0);
    tick();
    check("ill_flag", a_ill, 1);
    check("ill_rd_we", a_rd_we, 0);
    check("ill_type", a_type, 5'b00001);
    check("ill_op1", a_op1, 0);

    // addiw x1,x0,1
    drive(1, 32'h0010_009B, 64'h200C, 64'd0, 64'd0);
    tick();
    check("addiw_opc64", a_opc, 8'h21);
    check("addiw_op2_64", a_op2, 1);
    check("addiw_ill64", a_ill, 0);
    check("addiw_ill32", b_ill, 1);
    check("addiw_rd_we32", b_rd_we, 0);

    // flush with an entry held and a new input presented
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    tick();
    check("fl_held", a_ov, 1);
    drive(1, 32'h0051_0093, 64'h3000, 64'd7, 64'd0);
    flush = 1'b1;
    tick();
    check("fl_valid64", a_ov, 0);
    check("fl_valid32", b_ov, 0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_dropped", a_ov, 0);

    // asynchronous reset mid-stream
    drive(1, 32'h0051_0093, 64'h4000, 64'd7, 64'd0);
    tick();
    check("rs_pre_valid", a_ov, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_async_valid", a_ov, 0);
    check("rs_async_op1", a_op1, 0);
    check("rs_async_rd", a_rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rs_resume_valid", a_ov, 1);
    check("rs_resume_op1", a_op1, 7);
    check("rs_resume_pc", a_pc, 64'h4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
